axi4_mem_arb: RTL and testbench

- Synthesisable AXI4-lite slave memory with parametrised depth and data width.
- Shares one single-port SRAM between the AXI read channel, the AXI write channel and an accelerator port (e.g. the AES engine) under round-robin arbitration.
- Out-of-range AXI accesses return SLVERR instead of halting simulation.
- Sits between the CPU interconnect and on-chip RAM; gives accelerators direct memory access without CPU copy loops.

---
 rtl/axi4_mem_arb.sv | 206 ++++++++++++++++++++
 tb/tb_axi4_mem_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_arb.sv
// AXI4-lite slave memory sharing one single-port SRAM between the AXI read channel,
// the AXI write channel and an accelerator port, under round-robin arbitration.
module axi4_mem_arb #(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 32768,
  parameter int AW        = 32,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_axi_awvalid,
  output logic                mem_axi_awready,
  input  logic [AW-1:0]       mem_axi_awaddr,
  input  logic                mem_axi_wvalid,
  output logic                mem_axi_wready,
  input  logic [DATA_W-1:0]   mem_axi_wdata,
  input  logic [DATA_W/8-1:0] mem_axi_wstrb,
  output logic                mem_axi_bvalid,
  input  logic                mem_axi_bready,
  output logic [1:0]          mem_axi_bresp,
  input  logic                mem_axi_arvalid,
  output logic                mem_axi_arready,
  input  logic [AW-1:0]       mem_axi_araddr,
  output logic                mem_axi_rvalid,
  input  logic                mem_axi_rready,
  output logic [DATA_W-1:0]   mem_axi_rdata,
  output logic [1:0]          mem_axi_rresp,
  input  logic                acc_req,
  input  logic                acc_we,
  input  logic [IDX_W-1:0]    acc_idx,
  input  logic [DATA_W-1:0]   acc_wdata,
  input  logic [DATA_W/8-1:0] acc_wstrb,
  output logic                acc_gnt,
  output logic                acc_rvalid,
  output logic [DATA_W-1:0]   acc_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {SRC_R, SRC_W, SRC_A} src_e;

  src_e rr_q, rr_d;

  logic              ar_full, aw_full, w_full;
  logic              rd_issued, wr_issued;
  logic [AW-1:0]     ar_addr_q, aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic elig_r, elig_w, elig_a;
  logic gnt_r, gnt_w, gnt_a;

  logic [IDX_W-1:0] ar_idx, aw_idx;
  logic             ar_in_range, aw_in_range;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;

  // Ready outputs are gated by resetn so they are 0 for the whole reset window.
  assign mem_axi_awready = resetn & ~aw_full;
  assign mem_axi_wready  = resetn & ~w_full;
  assign mem_axi_arready = resetn & ~ar_full;

  assign elig_r = ar_full & ~rd_issued;
  assign elig_w = aw_full & w_full & ~wr_issued;
  assign elig_a = acc_req & resetn;

  assign ar_idx      = ar_addr_q[OFF_W +: IDX_W];
  assign aw_idx      = aw_addr_q[OFF_W +: IDX_W];
  assign ar_in_range = (ar_addr_q >> (OFF_W + IDX_W)) == '0;
  assign aw_in_range = (aw_addr_q >> (OFF_W + IDX_W)) == '0;

  assign acc_gnt = gnt_a;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_q <= SRC_R;
    else         rr_q <= rr_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rr_d = rr_q;
    if (gnt_r)      rr_d = SRC_W;
    else if (gnt_w) rr_d = SRC_A;
    else if (gnt_a) rr_d = SRC_R;
  end

  // Priority search starts at the pointer and wraps R -> W -> A -> R.
  always_comb begin
    gnt_r = 1'b0;
    gnt_w = 1'b0;
    gnt_a = 1'b0;
    case (rr_q)
      SRC_W: begin
        if (elig_w)      gnt_w = 1'b1;
        else if (elig_a) gnt_a = 1'b1;
        else if (elig_r) gnt_r = 1'b1;
      end
      SRC_A: begin
        if (elig_a)      gnt_a = 1'b1;
        else if (elig_r) gnt_r = 1'b1;
        else if (elig_w) gnt_w = 1'b1;
      end
      default: begin
        if (elig_r)      gnt_r = 1'b1;
        else if (elig_w) gnt_w = 1'b1;
        else if (elig_a) gnt_a = 1'b1;
      end
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (gnt_w) begin
      mem_we    = aw_in_range;
      mem_widx  = aw_idx;
      mem_wdata = w_data_q;
      mem_wstrb = w_strb_q;
    end else if (gnt_a) begin
      mem_we    = acc_we;
      mem_widx  = acc_idx;
      mem_wdata = acc_wdata;
      mem_wstrb = acc_wstrb;
    end
  end

  // NOTE: the SRAM array has no reset; its contents survive resetn.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (mem_wstrb[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_full        <= 1'b0;
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      rd_issued      <= 1'b0;
      wr_issued      <= 1'b0;
      ar_addr_q      <= '0;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= '0;
      mem_axi_rresp  <= RESP_OKAY;
      mem_axi_bvalid <= 1'b0;
      mem_axi_bresp  <= RESP_OKAY;
      acc_rvalid     <= 1'b0;
      acc_rdata      <= '0;
    end else begin
      if (mem_axi_arvalid && mem_axi_arready) begin
        ar_full   <= 1'b1;
        ar_addr_q <= mem_axi_araddr;
      end
      if (mem_axi_awvalid && mem_axi_awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= mem_axi_awaddr;
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        w_full   <= 1'b1;
        w_data_q <= mem_axi_wdata;
        w_strb_q <= mem_axi_wstrb;
      end

      if (gnt_r) begin
        rd_issued      <= 1'b1;
        mem_axi_rvalid <= 1'b1;
        mem_axi_rdata  <= ar_in_range ? mem[ar_idx] : '0;
        mem_axi_rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (mem_axi_rvalid && mem_axi_rready) begin
        mem_axi_rvalid <= 1'b0;
        ar_full        <= 1'b0;
        rd_issued      <= 1'b0;
      end

      if (gnt_w) begin
        wr_issued      <= 1'b1;
        mem_axi_bvalid <= 1'b1;
        mem_axi_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (mem_axi_bvalid && mem_axi_bready) begin
        mem_axi_bvalid <= 1'b0;
        aw_full        <= 1'b0;
        w_full         <= 1'b0;
        wr_issued      <= 1'b0;
      end

      acc_rvalid <= gnt_a & ~acc_we;
      if (gnt_a && !acc_we) acc_rdata <= mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_axi4_mem_arb.sv
// Self-checking bench for axi4_mem_arb: a cycle-level transaction model checked on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_axi4_mem_arb;

  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 32768;
  localparam int AW        = 32;
  localparam int IDX_W     = 15;
  localparam int TMO       = 40;
  localparam longint MEM_BYTES = longint'(MEM_WORDS) * 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              awvalid = 1'b0, awready;
  logic [AW-1:0]     awaddr = '0;
  logic              wvalid = 1'b0, wready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              bvalid, bready = 1'b0;
  logic [1:0]        bresp;
  logic              arvalid = 1'b0, arready;
  logic [AW-1:0]     araddr = '0;
  logic              rvalid, rready = 1'b0;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              acc_req = 1'b0, acc_we = 1'b0;
  logic [IDX_W-1:0]  acc_idx = '0;
  logic [31:0]       acc_wdata = '0;
  logic [3:0]        acc_wstrb = '0;
  logic              acc_gnt, acc_rvalid;
  logic [31:0]       acc_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_mem_arb #(.DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
    .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .mem_axi_rresp(rresp),
    .acc_req(acc_req), .acc_we(acc_we), .acc_idx(acc_idx), .acc_wdata(acc_wdata),
    .acc_wstrb(acc_wstrb), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within %0d cycles", name, TMO);
  endtask

  // ---------------- transaction model ----------------
  logic [31:0] mem_m [int unsigned];
  bit          m_ar_busy, m_r_issued, m_aw_busy, m_w_busy, m_w_issued;
  logic [31:0] m_ar_addr, m_aw_addr, m_w_data;
  logic [3:0]  m_w_strb;
  int          m_ptr;
  bit          e_rvalid, e_bvalid, e_acc_rvalid, e_rknown, e_aknown;
  logic [31:0] e_rdata, e_acc_rdata;
  logic [1:0]  e_rresp, e_bresp;
  bit          m_elig [3];
  int          m_gnt;
  bit          m_rdy_ar, m_rdy_aw, m_rdy_w;

  task automatic mwrite(input int unsigned idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    cur = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
    mem_m[idx] = cur;
  endtask

  always @(negedge clk) begin : model
    if (!resetn) begin
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_acc_rvalid", acc_rvalid, 0);
      check("rst_rdata", rdata, 0);
      m_ar_busy = 0; m_r_issued = 0; m_aw_busy = 0; m_w_busy = 0; m_w_issued = 0;
      e_rvalid = 0; e_bvalid = 0; e_acc_rvalid = 0; m_ptr = 0;
    end else begin
      check("awready", awready, !m_aw_busy);
      check("wready", wready, !m_w_busy);
      check("arready", arready, !m_ar_busy);
      check("rvalid", rvalid, e_rvalid);
      if (e_rvalid) check("rresp", rresp, e_rresp);
      if (e_rvalid && e_rknown) check("rdata", rdata, e_rdata);
      check("bvalid", bvalid, e_bvalid);
      if (e_bvalid) check("bresp", bresp, e_bresp);
      check("acc_rvalid", acc_rvalid, e_acc_rvalid);
      if (e_acc_rvalid && e_aknown) check("acc_rdata", acc_rdata, e_acc_rdata);

      m_elig[0] = m_ar_busy && !m_r_issued;
      m_elig[1] = m_aw_busy && m_w_busy && !m_w_issued;
      m_elig[2] = acc_req;
      m_gnt = -1;
      for (int k = 0; k < 3; k++) begin
        if (m_gnt < 0 && m_elig[(m_ptr + k) % 3]) m_gnt = (m_ptr + k) % 3;
      end
      check("acc_gnt", acc_gnt, m_gnt == 2);

      // Effects of the coming rising edge.
      m_rdy_ar = !m_ar_busy; m_rdy_aw = !m_aw_busy; m_rdy_w = !m_w_busy;
      if (e_rvalid && rready) begin e_rvalid = 0; m_ar_busy = 0; m_r_issued = 0; end
      if (e_bvalid && bready) begin
        e_bvalid = 0; m_aw_busy = 0; m_w_busy = 0; m_w_issued = 0;
      end
      e_acc_rvalid = 0;
      case (m_gnt)
        0: begin
          m_r_issued = 1; e_rvalid = 1;
          if (longint'(m_ar_addr) < MEM_BYTES) begin
            e_rknown = mem_m.exists(m_ar_addr / 4);
            e_rdata  = e_rknown ? mem_m[m_ar_addr / 4] : 32'h0;
            e_rresp  = 2'b00;
          end else begin
            e_rknown = 1; e_rdata = 32'h0; e_rresp = 2'b10;
          end
        end
        1: begin
          m_w_issued = 1; e_bvalid = 1;
          if (longint'(m_aw_addr) < MEM_BYTES) begin
            mwrite(m_aw_addr / 4, m_w_data, m_w_strb);
            e_bresp = 2'b00;
          end else e_bresp = 2'b10;
        end
        2: begin
          if (acc_we) mwrite(acc_idx, acc_wdata, acc_wstrb);
          else begin
            e_acc_rvalid = 1;
            e_aknown     = mem_m.exists(acc_idx);
            e_acc_rdata  = e_aknown ? mem_m[acc_idx] : 32'h0;
          end
        end
        default: ;
      endcase
      if (m_gnt >= 0) m_ptr = (m_gnt + 1) % 3;
      if (arvalid && m_rdy_ar) begin m_ar_busy = 1; m_ar_addr = araddr; end
      if (awvalid && m_rdy_aw) begin m_aw_busy = 1; m_aw_addr = awaddr; end
      if (wvalid && m_rdy_w) begin m_w_busy = 1; m_w_data = wdata; m_w_strb = wstrb; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; acc_req = 0; bready = 0; rready = 0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  // Presents AW and W together; returns once both handshakes are done.
  task automatic aw_w_together(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output bit ok);
    int n;
    bit aw_ok, w_ok;
    aw_ok = 0; w_ok = 0; n = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < TMO) begin
      @(negedge clk);
      n++;
      if (awvalid && awready) aw_ok = 1'b1;
      if (wvalid && wready) w_ok = 1'b1;
      tick();
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    ok = aw_ok && w_ok;
    if (!ok) timeout_fail("aw_w_handshake");
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_hold,
                           output logic [1:0] resp);
    int n;
    bit ok;
    resp = 2'bxx;
    if (w_lead > 0) begin
      awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < TMO);
      ok = wready;
      tick(); wvalid = 1'b0;
      repeat (w_lead - 1) tick();
      awvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < TMO);
      ok = ok && awready;
      tick(); awvalid = 1'b0;
      if (!ok) timeout_fail("w_first_handshake");
    end else begin
      aw_w_together(addr, data, strb, ok);
    end
    if (!ok) return;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < TMO);
    if (!bvalid) begin timeout_fail("bvalid_wait"); return; end
    resp = bresp;
    tick();
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      check("b_hold_awready", awready, 0);
      check("b_hold_wready", wready, 0);
      tick();
    end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int exp_lat,
                          output logic [31:0] data, output logic [1:0] resp);
    int n, hs_cyc;
    data = 'x; resp = 'x;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < TMO);
    if (!arready) begin timeout_fail("ar_handshake"); arvalid = 1'b0; return; end
    hs_cyc = cyc;
    tick(); arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < TMO);
    if (!rvalid) begin timeout_fail("rvalid_wait"); return; end
    if (exp_lat > 0) check("r_latency", cyc - hs_cyc, exp_lat);
    data = rdata; resp = rresp;
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  task automatic acc_access(input bit we, input logic [IDX_W-1:0] idx,
                            input logic [31:0] wd, input logic [3:0] ws);
    int n;
    acc_req = 1'b1; acc_we = we; acc_idx = idx; acc_wdata = wd; acc_wstrb = ws;
    n = 0;
    do begin @(negedge clk); n++; end while (!acc_gnt && n < TMO);
    if (!acc_gnt) timeout_fail("acc_gnt_wait");
    tick(); acc_req = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    logic [11:0] gnt_seq, rv_seq, bv_seq, arv_seq;
    bit          ok;
    int          n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_awready", awready, 0);
    check("reset_bvalid", bvalid, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Full-word write then read-back with best-case latency.
    axi_write(32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, resp);
    check("t1_bresp", resp, 2'b00);
    axi_read(32'h1000, 2, d, resp);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", resp, 2'b00);

    // W three cycles ahead of AW, partial strobes, B held off for 4 cycles.
    axi_write(32'h1000, 32'h11223344, 4'b0101, 3, 4, resp);
    check("t2_bresp", resp, 2'b00);
    axi_read(32'h1000, 2, d, resp);
    check("t2_rdata", d, 32'hDE22BE44);

    // Out-of-range write aliases word 0 when truncated; word 0 must stay intact.
    axi_write(32'h0000_0000, 32'h0000_1111, 4'hF, 0, 0, resp);
    axi_write(32'h0002_0000, 32'h5555_5555, 4'hF, 0, 0, resp);
    check("t3_bresp", resp, 2'b10);
    axi_read(32'h0000_0000, 2, d, resp);
    check("t3_word0", d, 32'h0000_1111);
    axi_read(32'h0002_0000, 2, d, resp);
    check("t3_oor_rdata", d, 32'h0);
    check("t3_oor_rresp", resp, 2'b10);

    // All three sources pending together from reset, then continuously requesting.
    do_reset();
    araddr = 32'h1000; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h1000; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    acc_req = 1'b1; acc_we = 1'b0; acc_idx = 15'h400;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      gnt_seq[k] = acc_gnt; rv_seq[k] = rvalid; bv_seq[k] = bvalid; arv_seq[k] = acc_rvalid;
      if (k == 1) check("t4_read_before_write", rdata, 32'hDE22BE44);
      if (k == 3) check("t4_acc_after_write", acc_rdata, 32'hCAFEF00D);
      if (k == 4) check("t4_read_after_write", rdata, 32'hCAFEF00D);
      tick();
    end
    acc_req = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (6) tick();
    rready = 1'b0; bready = 1'b0;
    check("t4_acc_gnt_pattern", gnt_seq, 12'h924);
    check("t4_rvalid_pattern", rv_seq, 12'h492);
    check("t4_bvalid_pattern", bv_seq, 12'h924);
    check("t4_acc_rvalid_pattern", arv_seq, 12'h248);

    // Accelerator write granted one cycle ahead of an AXI read of the same word.
    acc_access(1'b1, 15'd4, 32'h12345678, 4'hF);
    acc_req = 1'b1; acc_we = 1'b1; acc_idx = 15'd4; acc_wdata = 32'hA5A5A5A5; acc_wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h10; rready = 1'b0;
    @(negedge clk);
    check("t5_acc_gnt", acc_gnt, 1);
    check("t5_ar_accept", arready, 1);
    tick(); acc_req = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("t5_read_grant_cycle", acc_gnt, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_rvalid_held", rvalid, 1);
      check("t5_rdata_stable", rdata, 32'hA5A5A5A5);
      check("t5_arready_low", arready, 0);
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    acc_access(1'b0, 15'd4, 32'h0, 4'h0);
    @(negedge clk);
    check("t5_acc_rvalid", acc_rvalid, 1);
    check("t5_acc_rdata", acc_rdata, 32'hA5A5A5A5);
    tick();

    // Reset while a write response is pending.
    aw_w_together(32'h40, 32'h600DCAFE, 4'hF, ok);
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < TMO);
    if (!bvalid) timeout_fail("t6_bvalid_wait");
    tick();
    #2 resetn = 1'b0;
    #1;
    check("t6_bvalid_drop", bvalid, 0);
    check("t6_awready_in_reset", awready, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    bready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_b_after_reset", bvalid, 0);
      tick();
    end
    bready = 1'b0;
    axi_read(32'h40, 2, d, resp);
    check("t6_mem_kept", d, 32'h600DCAFE);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
